// File: rtl/rot_arbiter.sv
// rot_arbiter
//   Two requesters share one serial 4-bit rotate-right unit. A request is
//   accepted in IDLE, the operand is rotated one position per cycle in SHIFT,
//   and the result is presented for one cycle in DONE.
//
//   Configuration macro: RR_ARB_EN
//     defined   : round-robin between the two requesters on contention
//     undefined : requester 0 always wins on contention (fixed priority)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req0/req1        request, held high by the requester until granted
//   data0/data1      4-bit operand, sampled only at the accept edge
//   amt0/amt1        2-bit rotate-right amount, sampled only at the accept edge
//   gnt0/gnt1        one-cycle accept pulse
//   busy             high whenever the FSM is not in IDLE
//   out_valid        one-cycle result strobe (DONE cycle)
//   out_data         rotated result, held until the next DONE
//   out_id           requester that owns out_data
//
// Handshake: a requester keeps reqN high until it sees gntN. gntN is high for
// exactly the cycle after the accept edge; data/amt are captured at that
// edge, so the requester is free to change them from then on. Requests are
// only looked at in IDLE. Every output comes straight from a flop.

module rot_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [1:0] amt0,
  input  logic [1:0] amt1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] work, work_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       last_id, last_id_nxt;
  logic       gnt0_nxt, gnt1_nxt, busy_nxt, out_valid_nxt, out_id_nxt;
  logic [3:0] out_data_nxt;
  logic       win;

  // Winner selection. A lone requester always wins; only contention differs
  // between the two builds.
  always_comb begin
    win = ~req0;
`ifdef RR_ARB_EN
    if (req0 && req1) win = ~last_id;
`endif
  end

  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    cnt_nxt       = cnt;
    last_id_nxt   = last_id;
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    out_valid_nxt = 1'b0;
    out_data_nxt  = out_data;
    out_id_nxt    = out_id;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt   = SHIFT;
          work_nxt    = win ? data1 : data0;
          cnt_nxt     = win ? amt1 : amt0;
          out_id_nxt  = win;
          last_id_nxt = win;
          gnt0_nxt    = ~win;
          gnt1_nxt    = win;
        end
      end
      SHIFT: begin
        if (cnt != 2'd0) begin
          // rotate right by one: bit i takes bit i+1, bit 3 takes bit 0
          work_nxt = {work[0], work[3:1]};
          cnt_nxt  = cnt - 2'd1;
        end else begin
          state_nxt     = DONE;
          out_data_nxt  = work;
          out_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // busy is registered from the next state so it lines up with the state
    // register without decoding it combinationally at the output.
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= 4'b0000;
      cnt       <= 2'd0;
      last_id   <= 1'b1;  // requester 0 wins the first contention
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 4'b0000;
      out_id    <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      cnt       <= cnt_nxt;
      last_id   <= last_id_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_id    <= out_id_nxt;
    end
  end

endmodule

// File: tb/tb_rot_arbiter.sv
module tb_rot_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic [1:0] amt0, amt1;
  logic       gnt0, gnt1, busy, out_valid, out_id;
  logic [3:0] out_data;

  int n_total = 0;
  int n_pass  = 0;

  rot_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .amt0      (amt0),
    .amt1      (amt1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] d0;
    logic [1:0] a0;
    logic [3:0] d1;
    logic [1:0] a1;
    logic       hold;    // keep requests high after the grant
    logic       exp_id;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait for out_valid, sampling #1 after each edge; returns the edge count.
  task automatic wait_valid(output int edges, output int busy_cnt, input string name);
    edges = 0;
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      if (k == 0) chk({name, "_gnt_width"}, {6'd0, gnt1, gnt0}, 8'd0);
      if (out_valid) break;
    end
    if (!out_valid) chk({name, "_timeout"}, 8'd0, 8'd1);
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input string name);
    int edges, bcnt;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1;
    data0 = v.d0; amt0 = v.a0;
    data1 = v.d1; amt1 = v.a1;
    @(posedge clk); #1;                      // accept edge
    chk({name, "_gnt"}, {6'd0, gnt1, gnt0}, v.exp_id ? 8'd2 : 8'd1);
    chk({name, "_busy_on"}, {7'd0, busy}, 8'd1);
    @(negedge clk);
    if (!v.hold) begin req0 = 1'b0; req1 = 1'b0; end
    // operands after the accept edge must be ignored
    data0 = ~v.d0; data1 = ~v.d1; amt0 = ~v.a0; amt1 = ~v.a1;
    wait_valid(edges, bcnt, name);
    chk({name, "_latency"}, edges[7:0], {6'd0, v.exp_id ? v.a1 : v.a0} + 8'd1);
    chk({name, "_data"}, {4'd0, out_data}, {4'd0, v.exp_data});
    chk({name, "_id"}, {7'd0, out_id}, {7'd0, v.exp_id});
    @(negedge clk);
    data0 = v.d0; data1 = v.d1; amt0 = v.a0; amt1 = v.a1;
    @(posedge clk); #1;                      // DONE -> IDLE
    chk({name, "_valid_off"}, {7'd0, out_valid}, 8'd0);
    chk({name, "_busy_cycles"}, bcnt[7:0] + 8'd1, {6'd0, v.exp_id ? v.a1 : v.a0} + 8'd2);
    chk({name, "_data_hold"}, {4'd0, out_data}, {4'd0, v.exp_data});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    int edges, bcnt;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    data0 = 4'd0; data1 = 4'd0; amt0 = 2'd0; amt1 = 2'd0;

    //            r0    r1    d0       a0     d1       a1     hold  id    data
    vecs[0] = '{1'b1, 1'b0, 4'b1001, 2'd1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1100};
    vecs[1] = '{1'b0, 1'b1, 4'b1111, 2'd3, 4'b0111, 2'd2, 1'b0, 1'b1, 4'b1101};
    vecs[2] = '{1'b1, 1'b0, 4'b1000, 2'd3, 4'b0110, 2'd1, 1'b0, 1'b0, 4'b0001};
    vecs[3] = '{1'b1, 1'b0, 4'b1010, 2'd0, 4'b0101, 2'd2, 1'b0, 1'b0, 4'b1010};
    vecs[4] = '{1'b0, 1'b1, 4'b0110, 2'd2, 4'b1110, 2'd3, 1'b0, 1'b1, 4'b1101};
    // contention: both requesters held high for four back-to-back accepts
    vecs[5] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b1, 1'b0, 4'b1001};
`ifdef RR_ARB_EN
    vecs[6] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b1, 1'b1, 4'b0011};
    vecs[7] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b1, 1'b0, 4'b1001};
    vecs[8] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b0, 1'b1, 4'b0011};
`else
    vecs[6] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b1, 1'b0, 4'b1001};
    vecs[7] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b1, 1'b0, 4'b1001};
    vecs[8] = '{1'b1, 1'b1, 4'b0011, 2'd1, 4'b0110, 2'd1, 1'b0, 1'b0, 4'b1001};
`endif

    // reset state
    #12;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_gnt", {6'd0, gnt1, gnt0}, 8'd0);
    chk("rst_data", {4'd0, out_data}, 8'd0);
    chk("rst_id", {7'd0, out_id}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle with no request: nothing happens
    repeat (3) @(posedge clk);
    #1;
    chk("idle_noreq", {5'd0, busy, gnt1, gnt0}, 8'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // contention starts from a fresh reset so the pointer is known
    do_reset();
    for (int i = 5; i < 9; i++) run_vec(vecs[i], $sformatf("arb%0d", i - 5));

    // reset asserted mid-SHIFT aborts the operation
    @(negedge clk);
    req0 = 1'b1; data0 = 4'b1001; amt0 = 2'd3;
    @(posedge clk); #1;
    chk("abort_gnt", {6'd0, gnt1, gnt0}, 8'd1);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_valid", {7'd0, out_valid}, 8'd0);
    chk("abort_data", {4'd0, out_data}, 8'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_valid", {6'd0, out_valid, busy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{1'b0, 1'b1, 4'b0000, 2'd0, 4'b0101, 2'd1, 1'b0, 1'b1, 4'b1010}, "post_rst");

    // req1 arrives during another transaction's SHIFT and must wait
    @(negedge clk);
    req0 = 1'b1; data0 = 4'b0001; amt0 = 2'd2;
    @(posedge clk); #1;
    chk("wait_gnt0", {6'd0, gnt1, gnt0}, 8'd1);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1; data1 = 4'b0011; amt1 = 2'd1;
    edges = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      edges++;
      if (gnt1) break;
      if (out_valid) break;
    end
    chk("wait_no_gnt1", {7'd0, gnt1}, 8'd0);
    chk("wait_r0_data", {4'd0, out_data}, 8'b0100);
    chk("wait_r0_id", {7'd0, out_id}, 8'd0);
    @(negedge clk);
    data1 = 4'b1100; amt1 = 2'd2;
    @(posedge clk); #1;
    chk("wait_idle_gnt1", {6'd0, gnt1, busy}, 8'd0);
    @(posedge clk); #1;
    chk("wait_accept_gnt1", {6'd0, gnt1, gnt0}, 8'd2);
    @(negedge clk);
    req1 = 1'b0; data1 = 4'b0000; amt1 = 2'd0;
    wait_valid(edges, bcnt, "wait_r1");
    chk("wait_r1_latency", edges[7:0], 8'd3);
    chk("wait_r1_data", {4'd0, out_data}, 8'b0011);
    chk("wait_r1_id", {7'd0, out_id}, 8'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
